hdmi_tx_ctrl: RTL and testbench

Bring-up sequencer and source switch for the HDMI transmit path, clocked in the pixel clock domain. It watches the video MMCM lock, controls the asynchronous reset of the TMDS encoder/serializer, and enables video only on a frame boundary. It selects one of two pixel sources (internal colour bar or an external stream) and switches between them only at the start of a frame. Any loss of lock drops the path back to a blanked, reset state.

---
 rtl/hdmi_tx_ctrl_pkg.sv | 37 +++
 rtl/hdmi_tx_ctrl_sync_2ff.sv | 30 +++
 rtl/hdmi_tx_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hdmi_tx_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_tx_ctrl_pkg.sv
// hdmi_tx_ctrl_pkg: shared types and constants for the HDMI transmit
// bring-up sequencer.
//   ctrl_state_t : sequencer state encoding
//   vid_t        : video bundle {hs, vs, de, rgb[23:0]} used for sources and output
//   BLANK_RGB    : pixel value driven while the path is blanked
//   blank_vid()  : complete blanked bundle for a given vs polarity
package hdmi_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RELEASE,
    ST_WAIT_FRAME,
    ST_RUN
  } ctrl_state_t;

  localparam logic [23:0] BLANK_RGB = 24'h0;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } vid_t;

  // Blanked output: no sync, vs parked at its inactive level, no pixels.
  function automatic vid_t blank_vid(input logic vs_pol);
    vid_t v;
    v.hs  = 1'b0;
    v.vs  = ~vs_pol;
    v.de  = 1'b0;
    v.rgb = BLANK_RGB;
    return v;
  endfunction

endpackage

// File: rtl/hdmi_tx_ctrl_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single asynchronous level.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset, both flops load RST_VAL
//   d_i    : asynchronous input
//   q_o    : synchronized output, 2 clk latency
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  import hdmi_tx_ctrl_pkg::*;

  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hdmi_tx_ctrl.sv
// hdmi_tx_ctrl: bring-up sequencer and frame-aligned source switch for the
// HDMI transmit path (pixel clock domain).
//   clk_i, rst_i           : pixel clock, synchronous active-high reset
//   pll_locked_i           : MMCM lock (async, resynchronized here)
//   src_sel_i              : requested source, 0 = colour bar, 1 = external
//   s0_*_i / s1_*_i        : source timing and {r,g,b} pixel
//   enc_rst_n_o            : serializer reset, low = held in reset
//   hdmi_oen_o, running_o  : high only while streaming video
//   vid_*_o                : registered video to the serializer
//   active_src_o           : source currently driving vid_*
// Optional build macro HDMI_TX_CTRL_STATS_EN adds frame_cnt_o (frames seen
// while running) and lock_loss_cnt_o (saturating lock-loss count).
module hdmi_tx_ctrl
  import hdmi_tx_ctrl_pkg::*;
#(
  parameter int   SETTLE_CYCLES  = 1024,
  parameter int   RELEASE_CYCLES = 64,
  parameter logic VS_POL         = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pll_locked_i,
  input  logic        src_sel_i,
  input  logic        s0_hs_i,
  input  logic        s0_vs_i,
  input  logic        s0_de_i,
  input  logic [23:0] s0_rgb_i,
  input  logic        s1_hs_i,
  input  logic        s1_vs_i,
  input  logic        s1_de_i,
  input  logic [23:0] s1_rgb_i,
  output logic        enc_rst_n_o,
  output logic        hdmi_oen_o,
  output logic        vid_hs_o,
  output logic        vid_vs_o,
  output logic        vid_de_o,
  output logic [23:0] vid_rgb_o,
  output logic        active_src_o,
`ifdef HDMI_TX_CTRL_STATS_EN
  output logic [15:0] frame_cnt_o,
  output logic [7:0]  lock_loss_cnt_o,
`endif
  output logic        running_o
);

  localparam int CNT_MAX = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  ctrl_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            act_q, act_d;
  logic            pend_q;
  logic            lock_s, lock_lost;
  vid_t [1:0]      src_v;
  logic [1:0]      vs_prev_q, vs_edge;
  vid_t            vid_q, vid_d;
  logic            enc_q, oen_q, run_q;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  assign src_v[0] = {s0_hs_i, s0_vs_i, s0_de_i, s0_rgb_i};
  assign src_v[1] = {s1_hs_i, s1_vs_i, s1_de_i, s1_rgb_i};

  // Frame start = vs entering its active level on that source.
  for (genvar g = 0; g < 2; g++) begin : g_vs_edge
    assign vs_edge[g] = (src_v[g].vs == VS_POL) && (vs_prev_q[g] != VS_POL);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    lock_lost = !lock_s && (state_q inside {ST_SETTLE, ST_RELEASE, ST_WAIT_FRAME, ST_RUN});
    unique case (state_q)
      ST_HOLD:      state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_s) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == REL_LAST) begin
          state_d = ST_WAIT_FRAME;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_FRAME: begin
        if (vs_edge[pend_q]) begin
          state_d = ST_RUN;
          act_d   = pend_q;
        end
      end
      ST_RUN:       if (vs_edge[act_q]) act_d = pend_q;
      default:      state_d = ST_HOLD;
    endcase
    // Lock loss overrides any same-cycle frame start or switch.
    if (lock_lost) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      act_d   = act_q;
    end
    // Output register follows the next state so the first RUN cycle carries
    // the qualifying vs-edge sample of the (possibly new) active source.
    vid_d = (state_d == ST_RUN) ? src_v[act_d] : blank_vid(VS_POL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      act_q     <= 1'b0;
      pend_q    <= 1'b0;
      vs_prev_q <= {2{~VS_POL}};
      vid_q     <= blank_vid(VS_POL);
      enc_q     <= 1'b0;
      oen_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      pend_q    <= src_sel_i;
      vs_prev_q <= {src_v[1].vs, src_v[0].vs};
      vid_q     <= vid_d;
      // Registered decode keeps the serializer's async reset glitch-free.
      enc_q     <= state_d inside {ST_RELEASE, ST_WAIT_FRAME, ST_RUN};
      oen_q     <= (state_d == ST_RUN);
      run_q     <= (state_d == ST_RUN);
    end
  end

`ifdef HDMI_TX_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  lock_loss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q     <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      if (state_d == ST_WAIT_LOCK && state_q != ST_WAIT_LOCK)
        frame_cnt_q <= '0;
      else if (state_q == ST_RUN && vs_edge[act_q])
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if (lock_lost && lock_loss_cnt_q != 8'hFF)
        lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
    end
  end

  assign frame_cnt_o     = frame_cnt_q;
  assign lock_loss_cnt_o = lock_loss_cnt_q;
`endif

  assign enc_rst_n_o  = enc_q;
  assign hdmi_oen_o   = oen_q;
  assign running_o    = run_q;
  assign active_src_o = act_q;
  assign vid_hs_o     = vid_q.hs;
  assign vid_vs_o     = vid_q.vs;
  assign vid_de_o     = vid_q.de;
  assign vid_rgb_o    = vid_q.rgb;

endmodule

// File: tb/tb_hdmi_tx_ctrl.sv
module tb_hdmi_tx_ctrl;
  localparam int SC = 16;
  localparam int RC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pll, sel;
  logic s0_hs, s0_vs, s0_de, s1_hs, s1_vs, s1_de;
  logic [23:0] s0_rgb, s1_rgb;
  logic enc, oen, vhs, vvs, vde, act, run;
  logic [23:0] vrgb;
`ifdef HDMI_TX_CTRL_STATS_EN
  logic [15:0] fcnt;
  logic [7:0]  lcnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  hdmi_tx_ctrl #(.SETTLE_CYCLES(SC), .RELEASE_CYCLES(RC), .VS_POL(1'b1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pll_locked_i (pll),
    .src_sel_i    (sel),
    .s0_hs_i      (s0_hs),
    .s0_vs_i      (s0_vs),
    .s0_de_i      (s0_de),
    .s0_rgb_i     (s0_rgb),
    .s1_hs_i      (s1_hs),
    .s1_vs_i      (s1_vs),
    .s1_de_i      (s1_de),
    .s1_rgb_i     (s1_rgb),
    .enc_rst_n_o  (enc),
    .hdmi_oen_o   (oen),
    .vid_hs_o     (vhs),
    .vid_vs_o     (vvs),
    .vid_de_o     (vde),
    .vid_rgb_o    (vrgb),
    .active_src_o (act),
`ifdef HDMI_TX_CTRL_STATS_EN
    .frame_cnt_o     (fcnt),
    .lock_loss_cnt_o (lcnt),
`endif
    .running_o    (run)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance n clocks; land 1 ns after the edge for driving and sampling.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_enc"}, {31'b0, enc}, 32'd0);
    chk({tag, "_oen"}, {31'b0, oen}, 32'd0);
    chk({tag, "_hs"},  {31'b0, vhs}, 32'd0);
    chk({tag, "_vs"},  {31'b0, vvs}, 32'd0);
    chk({tag, "_de"},  {31'b0, vde}, 32'd0);
    chk({tag, "_rgb"}, {8'b0, vrgb}, 32'd0);
    chk({tag, "_act"}, {31'b0, act}, 32'd0);
    chk({tag, "_run"}, {31'b0, run}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; pll = 1'b0; sel = 1'b0;
    s0_hs = 1'b0; s0_vs = 1'b0; s0_de = 1'b0; s0_rgb = 24'h0;
    s1_hs = 1'b0; s1_vs = 1'b0; s1_de = 1'b0; s1_rgb = 24'h0;

    // Reset and bring-up
    cyc(5);
    chk_reset("rst");
    rst = 1'b0;
    cyc(1);
    pll = 1'b1;
    cyc(18);
    chk("enc_at18", {31'b0, enc}, 32'd0);
    cyc(1);
    chk("enc_at19", {31'b0, enc}, 32'd1);
    chk("run_rel", {31'b0, run}, 32'd0);
    cyc(6);
    chk("run_wf", {31'b0, run}, 32'd0);
    chk("oen_wf", {31'b0, oen}, 32'd0);
    s0_vs = 1'b1; s0_hs = 1'b1; s0_rgb = 24'h0A0B0C;
    cyc(1);
    chk("run_entry", {31'b0, run}, 32'd1);
    chk("oen_entry", {31'b0, oen}, 32'd1);
    chk("vs_entry",  {31'b0, vvs}, 32'd1);
    chk("hs_entry",  {31'b0, vhs}, 32'd1);
    chk("rgb_entry", {8'b0, vrgb}, 32'h0A0B0C);
    s0_hs = 1'b0; s0_vs = 1'b0; s0_de = 1'b1; s0_rgb = 24'h123456;
    cyc(1);
    chk("rgb_px0", {8'b0, vrgb}, 32'h123456);
    chk("de_px0",  {31'b0, vde}, 32'd1);
    chk("vs_px0",  {31'b0, vvs}, 32'd0);
    s0_rgb = 24'hABCDEF;
    cyc(1);
    chk("rgb_px1", {8'b0, vrgb}, 32'hABCDEF);

    // Source switch mid-frame: hold on s0 until its next vs edge
    s1_de = 1'b1; s1_rgb = 24'h111111; s0_rgb = 24'h222222; sel = 1'b1;
    cyc(2);
    chk("sw_hold_act", {31'b0, act}, 32'd0);
    chk("sw_hold_rgb", {8'b0, vrgb}, 32'h222222);
    s0_vs = 1'b1; s0_rgb = 24'h333333; s1_rgb = 24'h444444;
    cyc(1);
    chk("sw_act", {31'b0, act}, 32'd1);
    chk("sw_rgb_edge", {8'b0, vrgb}, 32'h444444);
    s0_vs = 1'b0; s1_rgb = 24'h555555;
    cyc(1);
    chk("sw_rgb_track", {8'b0, vrgb}, 32'h555555);
    // Several toggles in one frame: only the value at the edge counts
    sel = 1'b0; cyc(1); sel = 1'b1; cyc(1); sel = 1'b0; cyc(1); sel = 1'b1; cyc(1);
    s1_vs = 1'b1;
    cyc(1);
    chk("toggle_keep", {31'b0, act}, 32'd1);
    s1_vs = 1'b0; sel = 1'b0;
    cyc(1);
    s1_vs = 1'b1; s0_rgb = 24'hFF8000; s0_de = 1'b1;
    cyc(1);
    chk("swback_act", {31'b0, act}, 32'd0);
    chk("swback_rgb", {8'b0, vrgb}, 32'hFF8000);
    s1_vs = 1'b0;

    // Mid-frame lock loss
    pll = 1'b0; s0_vs = 1'b1;
    cyc(3);
    chk("ll_de",  {31'b0, vde}, 32'd0);
    chk("ll_rgb", {8'b0, vrgb}, 32'd0);
    chk("ll_oen", {31'b0, oen}, 32'd0);
    chk("ll_enc", {31'b0, enc}, 32'd0);
    chk("ll_vs",  {31'b0, vvs}, 32'd0);
    chk("ll_run", {31'b0, run}, 32'd0);
    pll = 1'b1;
    cyc(30);
    chk("relock_enc",  {31'b0, enc}, 32'd1);
    chk("relock_norun", {31'b0, run}, 32'd0);
    s0_vs = 1'b0;
    cyc(1);
    s0_vs = 1'b1;
    cyc(1);
    chk("relock_run", {31'b0, run}, 32'd1);
    chk("relock_vs",  {31'b0, vvs}, 32'd1);
    chk("relock_rgb", {8'b0, vrgb}, 32'hFF8000);

    // Reset while running on source 1
    s0_vs = 1'b0; sel = 1'b1;
    cyc(1);
    s0_vs = 1'b1;
    cyc(1);
    chk("pre_rst_act", {31'b0, act}, 32'd1);
    rst = 1'b1;
    cyc(1);
    chk_reset("midrst");
    rst = 1'b0; sel = 1'b0;

    // Lock glitch at settle count 10 restarts the full settle
    cyc(13);
    pll = 1'b0;
    cyc(2);
    pll = 1'b1;
    cyc(18);
    chk("glitch_enc_lo", {31'b0, enc}, 32'd0);
    cyc(1);
    chk("glitch_enc_hi", {31'b0, enc}, 32'd1);

`ifdef HDMI_TX_CTRL_STATS_EN
    rst = 1'b1;
    cyc(1);
    chk("st_rst_f", {16'b0, fcnt}, 32'd0);
    chk("st_rst_l", {24'b0, lcnt}, 32'd0);
    rst = 1'b0; s0_vs = 1'b0;
    cyc(30);
    for (int i = 0; i < 4; i++) begin
      s0_vs = 1'b1;
      cyc(1);
      s0_vs = 1'b0;
      cyc(3);
    end
    chk("st_run", {31'b0, run}, 32'd1);
    chk("st_frames", {16'b0, fcnt}, 32'd3);
    pll = 1'b0;
    cyc(3);
    chk("st_frames_clr", {16'b0, fcnt}, 32'd0);
    chk("st_losses", {24'b0, lcnt}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
